// File: rtl/wrr_lock_arb_vn_vc.sv
// Weighted round-robin arbiter over every (VN, VC) requester of one injector output port.
// Latency: grant is combinational in the same cycle; state advances on the clk edge ending a transfer.
// Backpressure: nothing moves until grant_ack; an unacked grant stays put with token/cnt/lock held.
module wrr_lock_arb_vn_vc #(
    parameter int NUM_VC      = 1,
    parameter int NUM_VN      = 3,
    parameter int WEIGHT_BITS = 4,
    parameter int LOCK_EN     = 1,
    localparam int N          = NUM_VN * NUM_VC,
    localparam int IDW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                          clk,
    input  logic                          rst_p,
    input  logic [N-1:0]                  vector_in,
    input  logic [N-1:0]                  tail_in,
    input  logic [NUM_VN*WEIGHT_BITS-1:0] weights_in,
    input  logic                          mode,
    input  logic                          grant_ack,
    output logic [N-1:0]                  vector_out,
    output logic [IDW-1:0]                grant_id,
    output logic                          grant_valid,
    output logic                          locked
);

    // Arbitration state
    logic [IDW-1:0]         token;
    logic [WEIGHT_BITS-1:0] cnt;
    logic [IDW-1:0]         last_id;
    logic                   locked_q;
    logic [IDW-1:0]         lock_id;

    // Combinational grant and next-state helpers
    logic                   found;
    logic [IDW-1:0]         g;
    int                     idx;
    int                     vn;
    logic [WEIGHT_BITS-1:0] w_raw;
    logic [WEIGHT_BITS:0]   w_eff;
    logic [WEIGHT_BITS:0]   served;
    logic [IDW-1:0]         g_inc;
    logic                   tail_g;
    logic                   xfer;
    logic                   pkt_done;

    // Pick the granted requester: the lock holder when locked, else first request from token upward
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = 0;
        if (locked_q) begin
            if (vector_in[lock_id]) begin
                found = 1'b1;
                g     = lock_id;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(token) + k;
                if (idx >= N) idx = idx - N;
                if (!found && vector_in[idx]) begin
                    found = 1'b1;
                    g     = IDW'(idx);
                end
            end
        end
        // Reset blanks the outputs even though the registers are still being cleared
        if (rst_p) begin
            found = 1'b0;
            g     = '0;
        end
    end

    // Drive the one-hot grant and its companions from the search result
    always_comb begin
        vector_out = '0;
        if (found) vector_out[g] = 1'b1;
    end

    assign grant_valid = found;
    assign grant_id    = g;
    assign locked      = locked_q & ~rst_p;

    assign tail_g   = tail_in[g];
    assign xfer     = found & grant_ack;
    assign pkt_done = xfer & (tail_g | (LOCK_EN == 0));
    // Explicit wrap so non-power-of-two N works
    assign g_inc    = (g == IDW'(N - 1)) ? '0 : g + 1'b1;

    // Per-VN weight of the granted requester; zero weight behaves as one packet per turn
    always_comb begin
        vn    = int'(g) / NUM_VC;
        w_raw = '0;
        for (int v = 0; v < NUM_VN; v++) begin
            if (v == vn) w_raw = weights_in[v*WEIGHT_BITS +: WEIGHT_BITS];
        end
        w_eff  = (w_raw == '0) ? (WEIGHT_BITS+1)'(1) : {1'b0, w_raw};
        served = (g == last_id) ? ({1'b0, cnt} + 1'b1) : (WEIGHT_BITS+1)'(1);
    end

    // Advance lock, token and turn counter only on an accepted flit
    always_ff @(posedge clk) begin
        if (rst_p) begin
            token    <= '0;
            cnt      <= '0;
            last_id  <= '0;
            locked_q <= 1'b0;
            lock_id  <= '0;
        end else if (xfer) begin
            if (tail_g) begin
                locked_q <= 1'b0;
            end else if (LOCK_EN != 0) begin
                locked_q <= 1'b1;
                lock_id  <= g;
            end
            if (pkt_done) begin
                if (!mode) begin
                    token <= g_inc;
                    cnt   <= '0;
                end else begin
                    last_id <= g;
                    if (served >= w_eff) begin
                        token <= g_inc;
                        cnt   <= '0;
                    end else begin
                        token <= g;
                        cnt   <= served[WEIGHT_BITS-1:0];
                    end
                end
            end
        end
    end

endmodule
